// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: circular (pc, instr, class) buffer frozen by a PC/wfi trigger, then drained oldest-first.
// Captures land one cycle after retirement; readout is combinational from storage and holds while rd_ready_i is low.
module retire_trace_buffer #(
   parameter int DEPTH        = 16,
   parameter int POST_TRIGGER = 8,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   arm_i,
   input  logic                   retire_valid_i,
   input  logic [31:0]            retire_pc_i,
   input  logic [31:0]            retire_instr_i,
   input  logic                   trig_pc_en_i,
   input  logic [31:0]            trig_pc_i,
   input  logic                   trig_wfi_en_i,
   output logic                   capturing_o,
   output logic                   triggered_o,
   output logic                   frozen_o,
   output logic                   rd_valid_o,
   input  logic                   rd_ready_i,
   output logic [31:0]            rd_pc_o,
   output logic [31:0]            rd_instr_o,
   output logic [2:0]             rd_class_o,
   output logic                   rd_last_o,
   output logic [COUNT_WIDTH-1:0] retired_count_o,
   output logic [COUNT_WIDTH-1:0] unknown_count_o
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_POST  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
   localparam logic [AW:0]   ONE_F   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PT_L    = POST_TRIGGER[AW-1:0];
   localparam logic [AW-1:0] ONE_P   = {{(AW-1){1'b0}}, 1'b1};

   logic [1:0]    state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill;
   logic [AW:0]   remaining;
   logic [AW-1:0] post_cnt;

   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic [2:0]    mem_cls   [DEPTH];

   logic [2:0]    cls;
   logic          capture;
   logic          is_trig;
   logic          go_drain;
   logic          xfer;
   logic [AW-1:0] wr_ptr_nxt;
   logic [AW:0]   fill_nxt;

   always_comb begin
      cls = 3'd7;
      if (retire_instr_i == 32'h10500073) begin
         cls = 3'd6;
      end else begin
         case (retire_instr_i[6:0])
            7'b0110111: cls = 3'd0;
            7'b0010111: cls = 3'd1;
            7'b0010011: cls = 3'd2;
            7'b0110011: cls = 3'd3;
            7'b1101111: cls = 3'd4;
            7'b1100111: cls = 3'd5;
            default:    cls = 3'd7;
         endcase
      end
   end

   // arm_i suppresses the same-cycle retirement entirely
   assign capture    = retire_valid_i && !arm_i && (state == S_ARMED || state == S_POST);
   assign is_trig    = (trig_pc_en_i && retire_pc_i == trig_pc_i) || (trig_wfi_en_i && cls == 3'd6);
   assign wr_ptr_nxt = wr_ptr + 1'b1;
   assign fill_nxt   = (fill == DEPTH_L) ? fill : fill + 1'b1;
   assign go_drain   = capture && ((state == S_ARMED && is_trig && POST_TRIGGER == 0) ||
                                   (state == S_POST && post_cnt == ONE_P));
   assign xfer       = rd_valid_o && rd_ready_i;

   assign capturing_o = (state == S_ARMED) || (state == S_POST);
   assign triggered_o = (state == S_POST) || (state == S_DRAIN);
   assign frozen_o    = (state == S_DRAIN);
   assign rd_valid_o  = (state == S_DRAIN) && (remaining != '0);
   assign rd_last_o   = rd_valid_o && (remaining == ONE_F);
   assign rd_pc_o     = rd_valid_o ? mem_pc[rd_ptr]    : '0;
   assign rd_instr_o  = rd_valid_o ? mem_instr[rd_ptr] : '0;
   assign rd_class_o  = rd_valid_o ? mem_cls[rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (capture) begin
         mem_pc[wr_ptr]    <= retire_pc_i;
         mem_instr[wr_ptr] <= retire_instr_i;
         mem_cls[wr_ptr]   <= cls;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fill            <= '0;
         remaining       <= '0;
         post_cnt        <= '0;
         retired_count_o <= '0;
         unknown_count_o <= '0;
      end else if (arm_i) begin
         state           <= S_ARMED;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fill            <= '0;
         remaining       <= '0;
         post_cnt        <= '0;
         retired_count_o <= '0;
         unknown_count_o <= '0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr_nxt;
            fill   <= fill_nxt;
            if (retired_count_o != '1) retired_count_o <= retired_count_o + 1'b1;
            if (cls == 3'd7 && unknown_count_o != '1) unknown_count_o <= unknown_count_o + 1'b1;
         end
         // oldest entry sits fill_nxt slots behind the post-capture write pointer
         if (go_drain) begin
            rd_ptr    <= wr_ptr_nxt - fill_nxt[AW-1:0];
            remaining <= fill_nxt;
         end
         case (state)
            S_ARMED: begin
               if (capture && is_trig) begin
                  post_cnt <= PT_L;
                  state    <= (POST_TRIGGER == 0) ? S_DRAIN : S_POST;
               end
            end
            S_POST: begin
               if (capture) begin
                  post_cnt <= post_cnt - 1'b1;
                  if (post_cnt == ONE_P) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (remaining == '0) begin
                  state <= S_IDLE;
               end else if (xfer) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == ONE_F) state <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboarded bench for retire_trace_buffer: instance a (POST_TRIGGER=8, 32-bit counters),
// instance b (POST_TRIGGER=0, 4-bit counters); a behavioural queue model supplies expectations.
module tb_retire_trace_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [2:0]  cls;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, arm_a, arm_b, retire_valid, trig_pc_en, trig_wfi_en, rd_ready, sel;
   logic [31:0] retire_pc, retire_instr, trig_pc;
   logic        rdy_a, rdy_b;

   logic        cap_a, trg_a, frz_a, vld_a, last_a;
   logic [31:0] pc_a, instr_a, ret_a, unk_a;
   logic [2:0]  cls_a;
   logic        cap_b, trg_b, frz_b, vld_b, last_b;
   logic [31:0] pc_b, instr_b;
   logic [3:0]  ret_b, unk_b;
   logic [2:0]  cls_b;

   logic        o_cap, o_trg, o_frz, o_vld, o_last;
   logic [31:0] o_pc, o_instr, o_ret, o_unk;
   logic [2:0]  o_cls;

   assign rdy_a   = sel ? 1'b0 : rd_ready;
   assign rdy_b   = sel ? rd_ready : 1'b0;
   assign o_cap   = sel ? cap_b : cap_a;
   assign o_trg   = sel ? trg_b : trg_a;
   assign o_frz   = sel ? frz_b : frz_a;
   assign o_vld   = sel ? vld_b : vld_a;
   assign o_last  = sel ? last_b : last_a;
   assign o_pc    = sel ? pc_b : pc_a;
   assign o_instr = sel ? instr_b : instr_a;
   assign o_cls   = sel ? cls_b : cls_a;
   assign o_ret   = sel ? {28'd0, ret_b} : ret_a;
   assign o_unk   = sel ? {28'd0, unk_b} : unk_a;

   retire_trace_buffer #(.DEPTH(16), .POST_TRIGGER(8), .COUNT_WIDTH(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .arm_i(arm_a), .retire_valid_i(retire_valid),
      .retire_pc_i(retire_pc), .retire_instr_i(retire_instr), .trig_pc_en_i(trig_pc_en),
      .trig_pc_i(trig_pc), .trig_wfi_en_i(trig_wfi_en), .capturing_o(cap_a),
      .triggered_o(trg_a), .frozen_o(frz_a), .rd_valid_o(vld_a), .rd_ready_i(rdy_a),
      .rd_pc_o(pc_a), .rd_instr_o(instr_a), .rd_class_o(cls_a), .rd_last_o(last_a),
      .retired_count_o(ret_a), .unknown_count_o(unk_a));

   retire_trace_buffer #(.DEPTH(16), .POST_TRIGGER(0), .COUNT_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .arm_i(arm_b), .retire_valid_i(retire_valid),
      .retire_pc_i(retire_pc), .retire_instr_i(retire_instr), .trig_pc_en_i(trig_pc_en),
      .trig_pc_i(trig_pc), .trig_wfi_en_i(trig_wfi_en), .capturing_o(cap_b),
      .triggered_o(trg_b), .frozen_o(frz_b), .rd_valid_o(vld_b), .rd_ready_i(rdy_b),
      .rd_pc_o(pc_b), .rd_instr_o(instr_b), .rd_class_o(cls_b), .rd_last_o(last_b),
      .retired_count_o(ret_b), .unknown_count_o(unk_b));

   int checks = 0;
   int errors = 0;

   ent_t        exp_q[$];
   int          m_state;   // 0 idle, 1 armed, 2 post, 3 frozen
   int          m_post, m_pt;
   logic [31:0] m_ret, m_unk, m_max;

   localparam logic [31:0] LUI  = 32'h000002b7;
   localparam logic [31:0] ADD  = 32'h00b50533;
   localparam logic [31:0] WFI  = 32'h10500073;
   localparam logic [31:0] UNK  = 32'hffffffff;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] cls_of(input logic [31:0] i);
      if (i == WFI) return 3'd6;
      case (i[6:0])
         7'h37:   return 3'd0;
         7'h17:   return 3'd1;
         7'h13:   return 3'd2;
         7'h33:   return 3'd3;
         7'h6f:   return 3'd4;
         7'h67:   return 3'd5;
         default: return 3'd7;
      endcase
   endfunction

   task automatic chk_status(input string tag);
      chk({tag, "_capturing"}, o_cap, (m_state == 1 || m_state == 2));
      chk({tag, "_triggered"}, o_trg, (m_state >= 2));
      chk({tag, "_frozen"},    o_frz, (m_state == 3));
      chk({tag, "_rd_valid"},  o_vld, (m_state == 3 && exp_q.size() > 0));
      chk({tag, "_retired"},   o_ret, m_ret);
      chk({tag, "_unknown"},   o_unk, m_unk);
   endtask

   task automatic select(input logic s);
      sel   = s;
      m_pt  = s ? 0 : 8;
      m_max = s ? 32'd15 : 32'hffffffff;
   endtask

   task automatic do_arm(input logic with_ret, input logic [31:0] pc, input logic [31:0] instr);
      if (sel) arm_b = 1'b1; else arm_a = 1'b1;
      retire_valid = with_ret;
      retire_pc    = pc;
      retire_instr = instr;
      exp_q.delete();
      m_state = 1; m_post = 0; m_ret = 0; m_unk = 0;
      @(posedge clk); @(negedge clk);
      arm_a = 1'b0; arm_b = 1'b0; retire_valid = 1'b0;
      chk_status("arm");
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
      ent_t e;
      logic [2:0] c;
      c = cls_of(instr);
      retire_valid = 1'b1; retire_pc = pc; retire_instr = instr;
      if (m_state == 1 || m_state == 2) begin
         e.pc = pc; e.instr = instr; e.cls = c;
         exp_q.push_back(e);
         if (exp_q.size() > 16) exp_q.delete(0);
         if (m_ret != m_max) m_ret++;
         if (c == 3'd7 && m_unk != m_max) m_unk++;
         if (m_state == 1) begin
            if ((trig_pc_en && pc == trig_pc) || (trig_wfi_en && c == 3'd6)) begin
               if (m_pt == 0) m_state = 3;
               else begin m_post = m_pt; m_state = 2; end
            end
         end else begin
            m_post--;
            if (m_post == 0) m_state = 3;
         end
      end
      @(posedge clk); @(negedge clk);
      retire_valid = 1'b0;
      chk_status("ret");
   endtask

   // pat 0: always ready; pat 1: ready 1,0,0,1,0,0...
   task automatic drain(input int pat, input int stop_after);
      int   cyc = 0;
      int   got = 0;
      ent_t e;
      while (exp_q.size() > 0 && got < stop_after && cyc < 300) begin
         rd_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
         chk("rd_valid", o_vld, 1'b1);
         if (rd_ready) begin
            e = exp_q.pop_front();
            chk("rd_pc",    o_pc,    e.pc);
            chk("rd_instr", o_instr, e.instr);
            chk("rd_class", o_cls,   e.cls);
            chk("rd_last",  o_last,  (exp_q.size() == 0));
            got++;
         end else begin
            chk("hold_pc",    o_pc,    exp_q[0].pc);
            chk("hold_instr", o_instr, exp_q[0].instr);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      rd_ready = 1'b0;
      if (got < stop_after) chk("drain_left", exp_q.size(), 0);
      if (exp_q.size() == 0) begin
         m_state = 0;
         chk_status("post_drain");
      end
   endtask

   initial begin
      rst_n = 1'b0; arm_a = 1'b0; arm_b = 1'b0; retire_valid = 1'b0; rd_ready = 1'b0;
      retire_pc = '0; retire_instr = '0; trig_pc = '0; trig_pc_en = 1'b0; trig_wfi_en = 1'b0;
      select(1'b0);
      exp_q.delete(); m_state = 0; m_post = 0; m_ret = 0; m_unk = 0;
      repeat (3) @(negedge clk);
      chk_status("rst_a");
      chk("rst_a_pc", o_pc, 0); chk("rst_a_cls", o_cls, 0); chk("rst_a_last", o_last, 0);
      select(1'b1);
      chk_status("rst_b");
      chk("rst_b_instr", o_instr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // No wrap: PC trigger on the 5th lui, 8 post captures
      select(1'b0);
      trig_pc_en = 1'b1; trig_pc = 32'h110; trig_wfi_en = 1'b0;
      do_arm(1'b0, 0, 0);
      for (int i = 0; i < 20; i++) retire(32'h100 + 4 * i, LUI | (i << 12));
      chk("nowrap_entries", exp_q.size(), 13);
      drain(0, 1000);

      // Wrap plus wfi trigger, drained under backpressure
      trig_pc_en = 1'b0; trig_wfi_en = 1'b1;
      do_arm(1'b0, 0, 0);
      for (int i = 0; i < 40; i++) retire(32'h2000 + 4 * i, ADD);
      retire(32'h20a0, WFI);
      for (int i = 0; i < 10; i++) retire(32'h20a4 + 4 * i, ADD);
      drain(1, 1000);

      // POST_TRIGGER=0: freeze right after wfi; 4-bit counter saturates
      select(1'b1);
      do_arm(1'b0, 0, 0);
      for (int i = 0; i < 40; i++) retire(32'h3000 + 4 * i, ADD);
      retire(32'h30a0, WFI);
      chk("wfi_entries", exp_q.size(), 16);
      drain(0, 1000);

      // Counter saturation without a trigger
      trig_wfi_en = 1'b0;
      do_arm(1'b0, 0, 0);
      for (int i = 0; i < 20; i++) retire(32'h4000 + 4 * i, (i % 2) ? UNK : ADD);

      // arm_i beats a same-cycle retirement that would otherwise trigger
      trig_pc_en = 1'b1; trig_pc = 32'h500;
      do_arm(1'b1, 32'h500, UNK);
      trig_pc = 32'h504;
      retire(32'h504, UNK);
      drain(0, 1000);

      // Reset in the middle of a drain, then re-arm with no retirements
      select(1'b0);
      trig_pc = 32'h600;
      do_arm(1'b0, 0, 0);
      for (int i = 0; i < 9; i++) retire(32'h600 + 4 * i, ADD);
      drain(0, 3);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      exp_q.delete(); m_state = 0; m_ret = 0; m_unk = 0;
      chk_status("midrst");
      chk("midrst_pc", o_pc, 0); chk("midrst_instr", o_instr, 0);
      chk("midrst_cls", o_cls, 0); chk("midrst_last", o_last, 0);
      rst_n = 1'b1;
      @(negedge clk);
      do_arm(1'b0, 0, 0);
      @(negedge clk);
      chk_status("rearm_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
